// File: rtl/mips_alu_pkg.sv
// ---------------------------------------------------------------------------
// mips_alu_pkg
// Shared definitions for the MIPS ALU and its arbitration wrapper:
//   - alu_ctrl_e : 3-bit ALU control codes
//   - FUNCT_*    : R-type funct codes understood by the shared ALU
//   - alu_decode : funct -> ALU control (unknown funct -> ALU_ERROR)
// ---------------------------------------------------------------------------
package mips_alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_XOR   = 3'd2,
    ALU_SLT   = 3'd3,
    ALU_AND   = 3'd4,
    ALU_ERROR = 3'd5,
    ALU_NOR   = 3'd6,
    ALU_OR    = 3'd7
  } alu_ctrl_e;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  function automatic alu_ctrl_e alu_decode(input logic [5:0] funct);
    alu_ctrl_e ctrl;
    case (funct)
      FUNCT_ADD: ctrl = ALU_ADD;
      FUNCT_SUB: ctrl = ALU_SUB;
      FUNCT_XOR: ctrl = ALU_XOR;
      FUNCT_SLT: ctrl = ALU_SLT;
      FUNCT_AND: ctrl = ALU_AND;
      FUNCT_NOR: ctrl = ALU_NOR;
      FUNCT_OR:  ctrl = ALU_OR;
      default:   ctrl = ALU_ERROR;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
// Request/response bundle between NREQ requesters, the result consumer and
// the shared-ALU arbiter.
//   req_valid  [NREQ]     per-requester operation valid
//   req_funct  [6*NREQ]   funct of requester i at [6i+5:6i]
//   req_a/b    [32*NREQ]  operands of requester i at [32i+31:32i]
//   req_ready  [NREQ]     one-hot grant
//   rsp_valid/rsp_ready   result slot handshake
//   rsp_id     [IDW]      requester that produced the result
//   rsp_result [32], rsp_zero
//   rsp_err, err_count[16]  only when ALU_SHARE_ERR_EN is defined
// Modports: master = requesters + consumer, slave = arbiter.
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IDW  = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [6*NREQ-1:0]  req_funct;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_result;
  logic               rsp_zero;
`ifdef ALU_SHARE_ERR_EN
  logic               rsp_err;
  logic [15:0]        err_count;

  modport master (
    output req_valid, req_funct, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, err_count
  );
  modport slave (
    input  req_valid, req_funct, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, err_count
  );
`else
  modport master (
    output req_valid, req_funct, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
  );
  modport slave (
    input  req_valid, req_funct, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
  );
`endif
endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered priority pointer.
//   clk, reset_n : clock, asynchronous active-low reset (pointer -> 0)
//   req  [N]     : request vector
//   enable       : grants are only issued (and the pointer only moves) when high
//   grant[N]     : one-hot grant, first requester at or above the pointer,
//                  wrapping modulo N; all-zero when disabled or idle
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int unsigned    PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0]    NW = (PW+1)'(N);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW-1:0] w_idx;
  logic [PW:0]   w_sum;
  logic [N-1:0]  w_grant;
  logic          w_found;

  // Scan N slots starting at the pointer; the one-bit-wider sum lets the
  // modulo-N wrap be a single conditional subtract for non-power-of-2 N.
  always_comb begin
    w_grant   = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= NW) w_sum = w_sum - NW;
      w_idx = w_sum[PW-1:0];
      if (!w_found && req[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_ptr_nxt      = (w_sum == NW - 1'b1) ? '0 : w_idx + 1'b1;
      end
    end
  end

  assign grant = enable ? w_grant : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (enable && w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one MIPS ALU among NREQ requesters. A round-robin arbiter picks one
// valid requester whenever the one-entry result slot is free (empty or being
// drained this cycle); its funct is decoded, the ALU evaluated, and the result
// registered into the slot one cycle after the accepting edge.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : alu_share_arbiter_if.slave (request vectors, req_ready grant,
//              rsp_valid/rsp_ready result handshake, rsp_id/result/zero)
// Optional: define ALU_SHARE_ERR_EN to add rsp_err and a saturating 16-bit
// err_count of captured illegal-funct operations.
// ---------------------------------------------------------------------------
module alu_share_arbiter
  import mips_alu_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IDW  = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_share_arbiter_if.slave  bus
);

  logic            r_valid;
  logic [IDW-1:0]  r_id;
  logic [31:0]     r_result;
  logic            r_zero;

  logic            w_slot_free;
  logic [NREQ-1:0] w_grant;
  logic            w_fire;
  logic [IDW-1:0]  w_id;
  logic [5:0]      w_funct;
  logic [31:0]     w_a;
  logic [31:0]     w_b;
  alu_ctrl_e       w_ctrl;
  logic [31:0]     w_result;

  assign w_slot_free = !r_valid || bus.rsp_ready;

  // reset_n in the enable keeps req_ready low for the whole reset window,
  // not just until the pointer flop clears.
  rr_arbiter #(.N(NREQ)) u_rr_arbiter (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (w_slot_free && reset_n),
    .req     (bus.req_valid),
    .grant   (w_grant)
  );

  assign bus.req_ready = w_grant;
  assign w_fire        = |w_grant;

  // One-hot grant -> winner index and operand mux.
  always_comb begin
    w_id    = '0;
    w_funct = '0;
    w_a     = '0;
    w_b     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_id    = IDW'(i);
        w_funct = bus.req_funct[6*i +: 6];
        w_a     = bus.req_a[32*i +: 32];
        w_b     = bus.req_b[32*i +: 32];
      end
    end
  end

  assign w_ctrl = alu_decode(w_funct);

  always_comb begin
    w_result = '0;
    case (w_ctrl)
      ALU_ADD: w_result = w_a + w_b;
      ALU_SUB: w_result = w_a - w_b;
      ALU_XOR: w_result = w_a ^ w_b;
      ALU_SLT: w_result = {31'b0, (w_a < w_b)};
      ALU_AND: w_result = w_a & w_b;
      ALU_NOR: w_result = ~(w_a | w_b);
      ALU_OR:  w_result = w_a | w_b;
      default: w_result = '0;
    endcase
  end

  // A grant only happens when the slot is free, so loading on a grant also
  // covers the simultaneous drain-and-refill case.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_fire) begin
      r_valid  <= 1'b1;
      r_id     <= w_id;
      r_result <= w_result;
      r_zero   <= (w_result == '0);
    end else if (r_valid && bus.rsp_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign bus.rsp_valid  = r_valid;
  assign bus.rsp_id     = r_id;
  assign bus.rsp_result = r_result;
  assign bus.rsp_zero   = r_zero;

`ifdef ALU_SHARE_ERR_EN
  logic        r_err;
  logic [15:0] r_err_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else if (w_fire) begin
      r_err <= (w_ctrl == ALU_ERROR);
      if ((w_ctrl == ALU_ERROR) && (r_err_count != '1)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign bus.rsp_err   = r_err;
  assign bus.err_count = r_err_count;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int NREQ = 3;
  localparam int IDW  = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) u_if ();

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   tests = 0;
  int   fails = 0;

  logic [NREQ-1:0] v;
  logic [5:0]      f [NREQ];
  logic [31:0]     a [NREQ];
  logic [31:0]     b [NREQ];

  int          m_ptr;
  logic        m_valid;
  logic [2:0]  m_id;
  logic [31:0] m_res;
  logic        m_zero;
  logic        m_err;
  int          m_cnt;

  function automatic logic [31:0] ref_alu(input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
    case (fn)
      6'h20: return x + y;
      6'h22: return x - y;
      6'h26: return x ^ y;
      6'h2A: return (x < y) ? 32'd1 : 32'd0;
      6'h24: return x & y;
      6'h27: return ~(x | y);
      6'h25: return x | y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic illegal(input logic [5:0] fn);
    case (fn)
      6'h20, 6'h22, 6'h26, 6'h2A, 6'h24, 6'h27, 6'h25: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    u_if.req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      u_if.req_funct[6*i +: 6] = f[i];
      u_if.req_a[32*i +: 32]   = a[i];
      u_if.req_b[32*i +: 32]   = b[i];
    end
  endtask

  task automatic set(input int i, input logic vv, input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
    v[i] = vv; f[i] = fn; a[i] = x; b[i] = y;
    drive();
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_id = 0; m_res = 0; m_zero = 0; m_err = 0; m_cnt = 0;
    sb.delete();
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".rsp_valid"},  u_if.rsp_valid,  m_valid);
    chk({tag, ".rsp_id"},     u_if.rsp_id,     m_id);
    chk({tag, ".rsp_result"}, u_if.rsp_result, m_res);
    chk({tag, ".rsp_zero"},   u_if.rsp_zero,   m_zero);
`ifdef ALU_SHARE_ERR_EN
    chk({tag, ".rsp_err"},    u_if.rsp_err,    m_err);
    chk({tag, ".err_count"},  u_if.err_count,  m_cnt);
`endif
  endtask

  // One clock: check the grant before the edge, push the expected result on
  // an accepted transfer, pop and compare once the DUT shows it after the edge.
  task automatic cycle();
    int          g;
    int          idx;
    logic        free;
    logic [2:0]  exp_rdy;
    exp_t        e;
    @(negedge clk);
    free = !m_valid || u_if.rsp_ready;
    g = -1;
    if (free) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
    chk("req_ready", u_if.req_ready, exp_rdy);
    if (g >= 0) begin
      sb.push_back('{g, ref_alu(f[g], a[g], b[g]), illegal(f[g])});
      glog.push_back(g);
      m_ptr = (g + 1) % NREQ;
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (u_if.rsp_valid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        m_valid = 1'b1;
        m_id    = 3'(e.id);
        m_res   = e.res;
        m_zero  = (e.res == 32'd0);
        m_err   = e.err;
        if (e.err && m_cnt != 16'hFFFF) m_cnt++;
      end else begin
        chk("rsp_valid_after_grant", u_if.rsp_valid, 1'b1);
        sb.delete();
      end
    end else if (m_valid && u_if.rsp_ready) begin
      m_valid = 1'b0;
    end
    chk_outputs("cyc");
  endtask

  int base;
  int order [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    v = '0;
    for (int i = 0; i < NREQ; i++) begin f[i] = 6'h20; a[i] = '0; b[i] = '0; end
    u_if.rsp_ready = 1'b1;
    drive();
    model_reset();

    // Reset with requests already pending: nothing is granted.
    reset_n = 1'b0;
    set(0, 1'b1, 6'h20, 32'd3, 32'd4);
    set(2, 1'b1, 6'h22, 32'd10, 32'd3);
    #1;
    chk("reset.req_ready", u_if.req_ready, 3'b000);
    chk_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    cycle();
    chk("first_grant_after_reset", glog[$], 0);
    v[0] = 1'b0; drive();
    cycle();
    chk("second_grant_after_reset", glog[$], 2);
    v = '0; drive();
    cycle();

    // Back-to-back on requester 1.
    set(1, 1'b1, 6'h20, 32'hFFFF_FFFF, 32'd1);
    cycle();
    chk("b2b.result", u_if.rsp_result, 32'd0);
    chk("b2b.zero", u_if.rsp_zero, 1'b1);
    chk("b2b.id", u_if.rsp_id, 3'd1);
    set(1, 1'b1, 6'h20, 32'd5, 32'd6);
    cycle();
    chk("b2b.second", u_if.rsp_result, 32'd11);
    set(1, 1'b1, 6'h22, 32'd0, 32'd1);
    cycle();
    chk("b2b.third", u_if.rsp_result, 32'hFFFF_FFFF);
    v[1] = 1'b0;
    set(2, 1'b1, 6'h25, 32'hF0, 32'h0F);
    cycle();
    v = '0; drive();

    // Fairness: pointer is now 0, all three continuously valid.
    set(0, 1'b1, 6'h20, 32'd1, 32'd2);
    set(1, 1'b1, 6'h24, 32'hFF, 32'h0F);
    set(2, 1'b1, 6'h25, 32'd1, 32'd2);
    base = glog.size();
    repeat (6) cycle();
    for (int j = 0; j < 6; j++) chk("rr_order", glog[base + j], order[j]);
    v = '0; drive();

    // Backpressure: SUB 5-7 held for 4 stalled cycles.
    set(0, 1'b1, 6'h22, 32'd5, 32'd7);
    cycle();
    chk("bp.result", u_if.rsp_result, 32'hFFFF_FFFE);
    v[0] = 1'b0;
    set(1, 1'b1, 6'h20, 32'd1, 32'd1);
    u_if.rsp_ready = 1'b0;
    repeat (4) cycle();
    chk("bp.held_result", u_if.rsp_result, 32'hFFFF_FFFE);
    chk("bp.held_id", u_if.rsp_id, 3'd0);
    u_if.rsp_ready = 1'b1;
    cycle();
    chk("bp.refill_id", u_if.rsp_id, 3'd1);
    chk("bp.refill_result", u_if.rsp_result, 32'd2);
    v = '0; drive();

    // Decode coverage on requester 0.
    set(0, 1'b1, 6'h2A, 32'd1, 32'h8000_0000);
    cycle(); chk("slt_unsigned_lt", u_if.rsp_result, 32'd1);
    set(0, 1'b1, 6'h2A, 32'h8000_0000, 32'd1);
    cycle(); chk("slt_unsigned_ge", u_if.rsp_result, 32'd0);
    set(0, 1'b1, 6'h27, 32'd0, 32'd0);
    cycle(); chk("nor", u_if.rsp_result, 32'hFFFF_FFFF);
    set(0, 1'b1, 6'h26, 32'hF0, 32'hFF);
    cycle(); chk("xor", u_if.rsp_result, 32'h0F);
    set(0, 1'b1, 6'h21, 32'd7, 32'd9);
    cycle();
    chk("illegal.result", u_if.rsp_result, 32'd0);
    chk("illegal.zero", u_if.rsp_zero, 1'b1);
`ifdef ALU_SHARE_ERR_EN
    chk("illegal.err", u_if.rsp_err, 1'b1);
    chk("illegal.count", u_if.err_count, 16'd1);
`endif
    set(0, 1'b1, 6'h24, 32'hF0F0, 32'hFF00);
    cycle(); chk("and", u_if.rsp_result, 32'hF000);
    v = '0; drive();

    // Lone requester 2, then pointer must have wrapped to 0.
    for (int j = 0; j < 4; j++) begin
      set(2, 1'b1, 6'h20, 32'(j), 32'(j * 3));
      cycle();
      chk("lone.id", u_if.rsp_id, 3'd2);
    end
    v = '0;
    set(1, 1'b1, 6'h20, 32'd1, 32'd1);
    set(0, 1'b1, 6'h20, 32'd2, 32'd2);
    cycle();
    chk("wrap_to_0", glog[$], 0);
    v = '0; drive();

    // Reset mid-traffic.
    set(0, 1'b1, 6'h20, 32'd1, 32'd1);
    set(1, 1'b1, 6'h20, 32'd2, 32'd2);
    set(2, 1'b1, 6'h20, 32'd3, 32'd3);
    cycle();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midreset.req_ready", u_if.req_ready, 3'b000);
    chk_outputs("midreset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    v[1] = 1'b0; drive();
    cycle();
    chk("midreset.first_grant", glog[$], 0);
    v = '0; drive();
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one MIPS ALU instance among NREQ requesters, e.g. integer pipe, branch-compare unit and address generator.
- Round-robin arbitration; funct-code-to-ALU-control decode; one-entry registered result slot with valid/ready backpressure.
- Sits between the requesters and the existing ALU and ALU-control logic, and owns all sequencing of the shared ALU.

Parameters:
- NREQ, 3, number of requesters (2..8).
- IDW, 3, width of the requester ID; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester operation valid.
- req_funct  input  6*NREQ  per-requester MIPS funct code; requester i at bits [6i+5:6i].
- req_a  input  32*NREQ  operand A per requester; requester i at bits [32i+31:32i].
- req_b  input  32*NREQ  operand B per requester, same packing as req_a.
- req_ready  output  NREQ  one-hot grant; the operation transfers when req_valid[i] and req_ready[i] are both high at a clock edge.
- rsp_valid  output  1  result slot holds a result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  index of the requester that produced the result.
- rsp_result  output  32  ALU result.
- rsp_zero  output  1  high when rsp_result == 0.

Behaviour:
- Reset (asynchronous, while reset_n is low):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0.
  - Round-robin pointer=0, so requester 0 has highest priority after reset.
  - req_ready=0 while reset_n is low.
- Slot free condition: slot_free = !rsp_valid || rsp_ready.
- Grant (combinational):
  - When slot_free, grant the first valid requester searching from the pointer upward, wrapping modulo NREQ.
  - req_ready is one-hot on that requester, or all-zero if no request is valid or the slot is not free.
  - req_ready never depends on req_funct, req_a or req_b.
- Capture (rising edge):
  - On a grant, load rsp_result, rsp_zero and rsp_id from the winner's operands; set rsp_valid=1.
  - Set pointer = (winner+1) mod NREQ.
- Drain with no new grant: when rsp_valid && rsp_ready, clear rsp_valid; rsp_result and rsp_id hold their last values.
- Simultaneous drain and grant: the new result replaces the old one in the same edge, so throughput is 1 op/cycle with no bubble.
- Latency: exactly 1 cycle from the accepting edge to rsp_valid high.
- Stall: while rsp_valid && !rsp_ready:
  - req_ready is all-zero.
  - All rsp_* outputs are stable.
  - The pointer is unchanged.
- Fairness: a continuously valid requester is granted within NREQ grants.
- Funct decode to 3-bit ALU control:
  - 0x20 ADD=0, 0x22 SUB=1, 0x26 XOR=2, 0x2A SLT=3, 0x24 AND=4, 0x27 NOR=6, 0x25 OR=7.
  - Any other funct gives ERROR=5, result 0.
- Arithmetic:
  - 32-bit, wrap-around, no overflow detection.
  - SLT is an unsigned compare: result 1 if A<B, else 0.
- Illegal funct: the operation is still accepted and consumes a grant; result 0, rsp_zero=1.
- Requesters must hold valid, funct and operands stable until the grant.
- Reset mid-operation discards any pending result; no partial transfer.

Optional Feature:
- Macro: ALU_SHARE_ERR_EN.
- Defined:
  - Adds output rsp_err (1 bit), registered with the result: 1 when the captured funct decoded to ERROR, else 0.
  - Resets to 0.
  - Also adds a 16-bit saturating output err_count, incremented on each captured illegal op, reset to 0, saturating at 0xFFFF.
- Undefined: neither port exists; illegal ops are distinguishable only by result 0.

Decomposition:
- Shared package mips_alu_pkg contains:
  - ALU control codes ADD/SUB/XOR/SLT/AND/ERROR/NOR/OR (values above).
  - Funct code constants.
  - A decode function from funct to ALU control.
- One sub-module: rr_arbiter.
  - Parameter N; inputs req[N], enable, clk, reset_n; output grant[N] one-hot.
  - Holds the pointer; advances only on an enabled non-zero grant.
- The ALU function is instantiated or inlined in the top-level block.

Test Plan:
- Reset check: assert reset_n=0 mid-traffic -> rsp_valid=0, req_ready=0, pointer=0 immediately; after release, req 0 and req 2 valid -> req 0 granted first.
- Back-to-back ops: req1 ADD A=0xFFFFFFFF B=1, rsp_ready=1 -> next cycle rsp_result=0, rsp_zero=1, rsp_id=1; continuous issue -> one result per cycle.
- Round-robin fairness: all 3 valid continuously, rsp_ready=1 -> grant order 0,1,2,0,1,2; no requester waits more than 3 grants.
- Backpressure: rsp_ready=0 for 4 cycles with result SUB 5-7=0xFFFFFFFE held -> req_ready=0 and outputs stable; rsp_ready=1 -> drain plus new grant on the same edge.
- Decode coverage: SLT 1<0x80000000 -> 1 (unsigned); NOR 0,0 -> 0xFFFFFFFF; XOR 0xF0,0xFF -> 0x0F; funct 0x21 -> result 0, rsp_zero=1 (rsp_err=1 and err_count=1 with ALU_SHARE_ERR_EN).
- Lone requester: only req 2 valid repeatedly -> granted every cycle; pointer wraps to 0.
